// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder
// Message-side front end for the SHA-1 core. Collects a byte stream into a
// single 512-bit buffer, appends the 0x80 marker, zero fill and the 64-bit
// big-endian bit length, and hands out one block at a time.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   in_data      message byte
//   in_valid     in_data valid
//   in_last      marks the final byte of the message
//   in_empty     (only with SHA1_PAD_EMPTY_EN) final beat carries no byte
//   in_ready     byte accepted on the edge where in_valid & in_ready
//   block        padded block, byte 0 in [511:504], byte 63 in [7:0]
//   block_valid  block holds a complete block
//   block_ready  consumer takes the block on valid & ready
//   block_last   block is the final block of the current message
//
// Optional feature macro: SHA1_PAD_EMPTY_EN adds in_empty so that
// zero-length messages can be expressed.
module sha1_msg_padder #(
    parameter int LEN_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
`ifdef SHA1_PAD_EMPTY_EN
    input  logic         in_empty,
`endif
    output logic         in_ready,
    output logic [511:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last
);

    typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;

    state_t               state_q, state_d;
    state_t               pending_q, pending_d;
    logic [6:0]           pos_q, pos_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [511:0]         block_q, block_d;
    logic                 blockValid_q, blockValid_d;
    logic                 blockLast_q, blockLast_d;
    logic                 inReady_q, inReady_d;
    logic                 padStarted_q, padStarted_d;

    logic                 accept;
    logic                 emptyBeat;
    logic                 wrEn;
    logic [7:0]           wrByte;
    logic [63:0]          lenBits;
    logic [8:0]           bitBase;

`ifdef SHA1_PAD_EMPTY_EN
    assign emptyBeat = in_last & in_empty;
`else
    assign emptyBeat = 1'b0;
`endif

    // in_ready is a register that is only ever set while the FSM is in FILL,
    // so it alone qualifies an accepted beat.
    assign accept  = in_valid & inReady_q;
    assign lenBits = 64'(count_q) << 3;
    // Byte index pos maps to bit offset (63 - pos) * 8 in the buffer.
    assign bitBase = {~pos_q[5:0], 3'b000};

    // Next-state logic: every state writes at most one byte per cycle into
    // the buffer at pos. Blocks always leave through EMIT, which remembers
    // where to resume (FILL for more data, PAD when padding spilled over).
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pos_d        = pos_q;
        count_d      = count_q;
        block_d      = block_q;
        blockValid_d = blockValid_q;
        blockLast_d  = blockLast_q;
        padStarted_d = padStarted_q;
        wrEn         = 1'b0;
        wrByte       = 8'h00;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (!emptyBeat) begin
                        wrEn    = 1'b1;
                        wrByte  = in_data;
                        pos_d   = pos_q + 7'd1;
                        count_d = count_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (in_last) begin
                        padStarted_d = 1'b0;
                        if (pos_d == 7'd64) begin
                            state_d      = EMIT;
                            pending_d    = PAD;
                            blockValid_d = 1'b1;
                        end else begin
                            state_d = PAD;
                        end
                    end else if (pos_d == 7'd64) begin
                        state_d      = EMIT;
                        pending_d    = FILL;
                        blockValid_d = 1'b1;
                    end
                end
            end

            PAD: begin
                // The marker byte goes out exactly once per message, even
                // when padding continues into a second block.
                wrEn         = 1'b1;
                wrByte       = padStarted_q ? 8'h00 : 8'h80;
                padStarted_d = 1'b1;
                pos_d        = pos_q + 7'd1;
                if (pos_d == 7'd56) begin
                    state_d = LEN;
                end else if (pos_d == 7'd64) begin
                    state_d      = EMIT;
                    pending_d    = PAD;
                    blockValid_d = 1'b1;
                end
            end

            LEN: begin
                // pos 56..63 selects length bytes MSB first.
                wrEn   = 1'b1;
                wrByte = lenBits[{~pos_q[2:0], 3'b000} +: 8];
                pos_d  = pos_q + 7'd1;
                if (pos_d == 7'd64) begin
                    state_d      = EMIT;
                    pending_d    = FILL;
                    blockValid_d = 1'b1;
                    blockLast_d  = 1'b1;
                end
            end

            EMIT: begin
                if (block_ready) begin
                    blockValid_d = 1'b0;
                    pos_d        = 7'd0;
                    block_d      = '0;
                    state_d      = pending_q;
                    if (blockLast_q) begin
                        count_d     = '0;
                        blockLast_d = 1'b0;
                        state_d     = FILL;
                    end
                end
            end

            default: state_d = FILL;
        endcase

        if (wrEn) begin
            block_d[bitBase +: 8] = wrByte;
        end
    end

    assign inReady_d = (state_d == FILL);

    // State and all outputs are registered here; reset aborts any message
    // in flight and drops in_ready for the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            pending_q    <= FILL;
            pos_q        <= 7'd0;
            count_q      <= '0;
            block_q      <= '0;
            blockValid_q <= 1'b0;
            blockLast_q  <= 1'b0;
            inReady_q    <= 1'b0;
            padStarted_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pos_q        <= pos_d;
            count_q      <= count_d;
            block_q      <= block_d;
            blockValid_q <= blockValid_d;
            blockLast_q  <= blockLast_d;
            inReady_q    <= inReady_d;
            padStarted_q <= padStarted_d;
        end
    end

    assign in_ready    = inReady_q;
    assign block       = block_q;
    assign block_valid = blockValid_q;
    assign block_last  = blockLast_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder
// Directed bench for sha1_msg_padder: short, boundary-length and stalled
// messages with hand-built expected blocks. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_sha1_msg_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
`ifdef SHA1_PAD_EMPTY_EN
    logic         in_empty = 1'b0;
`endif
    logic         in_ready;
    logic [511:0] block;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic         block_last;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    sha1_msg_padder #(.LEN_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
`ifdef SHA1_PAD_EMPTY_EN
        .in_empty    (in_empty),
`endif
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one byte (called on a falling edge) and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] d, input logic last);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) checkOutput("acceptTimeout", {511'd0, in_ready}, 512'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Message of n bytes whose values are 0, 1, 2, ...
    task automatic sendCounting(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(i[7:0], (i == n - 1));
        end
    endtask

    // Wait for a block, capture it and hand it off with a one-cycle ready.
    task automatic getBlock(output logic [511:0] blk, output logic lst, output int riseEdge);
        int guard;
        guard = 0;
        blk = '0;
        lst = 1'b0;
        riseEdge = 0;
        while (block_valid !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (block_valid !== 1'b1) begin
            checkOutput("blockTimeout", {511'd0, block_valid}, 512'd1);
        end else begin
            blk = block;
            lst = block_last;
            riseEdge = cycleCount;
            block_ready = 1'b1;
            @(negedge clk);
            block_ready = 1'b0;
        end
    endtask

    function automatic logic [511:0] countingBlock(input int n);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[511 - 8*i -: 8] = i[7:0];
        return b;
    endfunction

    function automatic logic [511:0] withByte(input logic [511:0] b, input int idx, input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[511 - 8*idx -: 8] = v;
        return r;
    endfunction

    logic [511:0] blk, exp, snap;
    logic         lst, snapLast, stable;
    int           rise, acceptEdge;
    logic [511:0] expAbc;

    initial begin
        expAbc = {32'h61626380, 416'd0, 64'h18};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstInReady", {511'd0, in_ready}, 512'd0);
        checkOutput("rstValid", {511'd0, block_valid}, 512'd0);
        checkOutput("rstLast", {511'd0, block_last}, 512'd0);
        checkOutput("rstBlock", block, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postRstInReady", {511'd0, in_ready}, 512'd1);

        // "abc" with latency check
        applyStimulus(8'h61, 1'b0);
        applyStimulus(8'h62, 1'b0);
        applyStimulus(8'h63, 1'b1);
        acceptEdge = cycleCount;
        getBlock(blk, lst, rise);
        checkOutput("abcBlock", blk, expAbc);
        checkOutput("abcLast", {511'd0, lst}, 512'd1);
        checkOutput("abcLatency", 512'(rise - acceptEdge), 512'd61);

        // 55 bytes: marker and length fit in one block
        sendCounting(55);
        getBlock(blk, lst, rise);
        exp = withByte(countingBlock(55), 55, 8'h80);
        exp[63:0] = 64'h1B8;
        checkOutput("len55Block", blk, exp);
        checkOutput("len55Last", {511'd0, lst}, 512'd1);

        // 56 bytes: length spills into a second block
        sendCounting(56);
        getBlock(blk, lst, rise);
        checkOutput("len56Blk1", blk, withByte(countingBlock(56), 56, 8'h80));
        checkOutput("len56Last1", {511'd0, lst}, 512'd0);
        getBlock(blk, lst, rise);
        checkOutput("len56Blk2", blk, {448'd0, 64'h1C0});
        checkOutput("len56Last2", {511'd0, lst}, 512'd1);

        // 64 bytes: last byte fills the block, marker starts the next one
        sendCounting(64);
        getBlock(blk, lst, rise);
        checkOutput("len64Blk1", blk, countingBlock(64));
        checkOutput("len64Last1", {511'd0, lst}, 512'd0);
        getBlock(blk, lst, rise);
        checkOutput("len64Blk2", blk, {8'h80, 440'd0, 64'h200});
        checkOutput("len64Last2", {511'd0, lst}, 512'd1);

        // Stall: block held for 10 cycles while a 65th byte waits
        for (int i = 0; i < 64; i++) applyStimulus(i[7:0], 1'b0);
        checkOutput("stallValid", {511'd0, block_valid}, 512'd1);
        checkOutput("stallInReady", {511'd0, in_ready}, 512'd0);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        in_last  = 1'b1;
        snap     = block;
        snapLast = block_last;
        stable   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (block !== snap || block_last !== snapLast || block_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        checkOutput("stallStable", {511'd0, stable}, 512'd1);
        checkOutput("stallBlk1", snap, countingBlock(64));
        checkOutput("stallLast1", {511'd0, snapLast}, 512'd0);
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        applyStimulus(8'hA5, 1'b1);
        getBlock(blk, lst, rise);
        checkOutput("stallBlk2", blk, {16'hA580, 432'd0, 64'h208});
        checkOutput("stallLast2", {511'd0, lst}, 512'd1);

        // Reset mid-fill, then "abc" must match the first result
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstInReady", {511'd0, in_ready}, 512'd0);
        checkOutput("midRstBlock", block, 512'd0);
        reset = 1'b0;
        applyStimulus(8'h61, 1'b0);
        applyStimulus(8'h62, 1'b0);
        applyStimulus(8'h63, 1'b1);
        getBlock(blk, lst, rise);
        checkOutput("abc2Block", blk, expAbc);
        checkOutput("abc2Last", {511'd0, lst}, 512'd1);

`ifdef SHA1_PAD_EMPTY_EN
        // Zero-length message via an empty final beat
        in_empty = 1'b1;
        applyStimulus(8'hFF, 1'b1);
        in_empty = 1'b0;
        getBlock(blk, lst, rise);
        checkOutput("emptyBlock", blk, {8'h80, 504'd0});
        checkOutput("emptyLast", {511'd0, lst}, 512'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
